// File: rtl/regfile_pkg.sv
// Shared constants, wait-FSM encoding and write-back stage layout for the
// MIPS register file with registered write-back.
package regfile_pkg;

    localparam int unsigned REG_ZERO   = 0;
    localparam int unsigned PC_INCR    = 4;
    localparam int unsigned CNT_W      = 8;   // holds MEM_TIMEOUT up to 255
    localparam int unsigned REG_DATA_W = 32;  // default data width
    localparam int unsigned REG_ADDR_W = 5;   // default index width

    // Load-wait FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } wait_state_e;

    // Write-back stage entry at the default widths (used by monitors/benches;
    // the RTL keeps a width-parametrised copy of the same layout).
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_DATA_W-1:0] data;
    } wb_stage_t;

    // Link register is the all-ones index for a given index width
    function automatic int unsigned link_idx(input int unsigned aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

endpackage

// File: rtl/regfile_wb_stage.sv
// Write-back front end: selects destination and data, runs the load-wait
// FSM with timeout, and holds the one-entry write-back stage register.
module regfile_wb_stage
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  regWrite_i,
    input  logic                  regDest_i,
    input  logic                  memToReg_i,
    input  logic                  jalSignal_i,
    input  logic [ADDR_WIDTH-1:0] rt_i,
    input  logic [ADDR_WIDTH-1:0] rd_i,
    input  logic [DATA_WIDTH-1:0] aluData_i,
    input  logic [DATA_WIDTH-1:0] memData_i,
    input  logic                  memValid_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  stall_o,
    output logic                  memError_o,
    output logic                  wb_valid_o,
    output logic [ADDR_WIDTH-1:0] wb_dest_o,
    output logic [DATA_WIDTH-1:0] wb_data_o
);

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] dest;
        logic [DATA_WIDTH-1:0] data;
    } stage_t;

    localparam logic [ADDR_WIDTH-1:0] LINK    = ADDR_WIDTH'(link_idx(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] ZERO    = ADDR_WIDTH'(REG_ZERO);
    localparam logic [CNT_W-1:0]      TIMEOUT = CNT_W'(MEM_TIMEOUT);

    wait_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    stage_t                stage_q, stage_d;
    logic                  accept;
    logic                  stall;
    logic                  needs_mem;
    logic [ADDR_WIDTH-1:0] dest_mux;
    logic [DATA_WIDTH-1:0] data_mux;

    // Destination/data select; jal overrides both other selects
    always_comb begin
        dest_mux  = jalSignal_i ? LINK : (regDest_i ? rd_i : rt_i);
        data_mux  = jalSignal_i ? (pc_i + DATA_WIDTH'(PC_INCR))
                                : (memToReg_i ? memData_i : aluData_i);
        needs_mem = memToReg_i && !jalSignal_i;
    end

    // Wait FSM next state, accept and stall. The timeout cycle itself does
    // not stall, so a dead load holds the requester for MEM_TIMEOUT cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        accept  = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (regWrite_i) begin
                    if (needs_mem && !memValid_i) begin
                        stall   = 1'b1;
                        state_d = WAIT;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        accept = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!regWrite_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (memValid_i) begin
                    accept  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT) begin
                    state_d = ABORT;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage load: writes to register 0 are accepted but never become valid
    always_comb begin
        stage_d.valid = accept && (dest_mux != ZERO);
        stage_d.dest  = dest_mux;
        stage_d.data  = data_mux;
    end

    // FSM, counter, sticky error and write-back stage registers
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            stage_q <= stage_d;
        end
    end

    assign stall_o    = stall;
    assign memError_o = err_q;
    assign wb_valid_o = stage_q.valid;
    assign wb_dest_o  = stage_q.dest;
    assign wb_data_o  = stage_q.data;

endmodule

// File: rtl/register_file_wb.sv
// MIPS register file with registered write-back stage and load-wait stall.
// Optional macro REGFILE_BYPASS_EN: reads matching the valid write-back
// stage destination return stage data instead of the (stale) array.
module register_file_wb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic [ADDR_WIDTH-1:0] rt,
    input  logic [ADDR_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0] data1,
    output logic [DATA_WIDTH-1:0] data2,
    input  logic                  regWrite,
    input  logic                  regDest,
    input  logic                  memToReg,
    input  logic                  jalSignal,
    input  logic [DATA_WIDTH-1:0] aluData,
    input  logic [DATA_WIDTH-1:0] memData,
    input  logic                  memValid,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  stall,
    output logic                  memError
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_dest;
    logic [DATA_WIDTH-1:0] wb_data;

    regfile_wb_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wb (
        .clock      (clock),
        .resetN     (resetN),
        .regWrite_i (regWrite),
        .regDest_i  (regDest),
        .memToReg_i (memToReg),
        .jalSignal_i(jalSignal),
        .rt_i       (rt),
        .rd_i       (rd),
        .aluData_i  (aluData),
        .memData_i  (memData),
        .memValid_i (memValid),
        .pc_i       (pc),
        .stall_o    (stall),
        .memError_o (memError),
        .wb_valid_o (wb_valid),
        .wb_dest_o  (wb_dest),
        .wb_data_o  (wb_data)
    );

    // Array commit from the write-back stage (stage is never valid for reg 0)
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wb_valid) begin
            regs_q[wb_dest] <= wb_data;
        end
    end

    // Read ports: index 0 reads 0; optional forward from the pending stage
    always_comb begin
        data1 = (rs == ZERO) ? '0 : regs_q[rs];
        data2 = (rt == ZERO) ? '0 : regs_q[rt];
`ifdef REGFILE_BYPASS_EN
        if (wb_valid && (wb_dest == rs) && (rs != ZERO)) data1 = wb_data;
        if (wb_valid && (wb_dest == rt) && (rt != ZERO)) data2 = wb_data;
`endif
    end

endmodule

// File: tb/tb_register_file_wb.sv
// Directed bench for register_file_wb: scoreboard of expected register
// contents pushed at request time, popped and checked after commit.
module tb_register_file_wb;
    import regfile_pkg::*;

    logic        clock = 1'b0;
    logic        resetN;
    logic [4:0]  rs, rt, rd;
    logic [31:0] data1, data2;
    logic        regWrite, regDest, memToReg, jalSignal, memValid;
    logic [31:0] aluData, memData, pc;
    logic        stall, memError;

    int total = 0;
    int bad   = 0;
    int n;
    wb_stage_t sb[$];

    register_file_wb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .MEM_TIMEOUT(15)) dut (
        .clock(clock), .resetN(resetN), .rs(rs), .rt(rt), .rd(rd),
        .data1(data1), .data2(data2), .regWrite(regWrite), .regDest(regDest),
        .memToReg(memToReg), .jalSignal(jalSignal), .aluData(aluData),
        .memData(memData), .memValid(memValid), .pc(pc), .stall(stall),
        .memError(memError)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        regWrite = 1'b0; regDest = 1'b0; memToReg = 1'b0; jalSignal = 1'b0;
        memValid = 1'b0; aluData = '0; memData = '0; pc = '0; rd = '0;
    endtask

    task automatic push(input logic [4:0] d, input logic [31:0] v);
        wb_stage_t e;
        e.valid = 1'b1;
        e.dest  = d;
        e.data  = (d == 5'd0) ? 32'd0 : v;
        sb.push_back(e);
    endtask

    // ALU write to rd; request must be accepted in the same cycle
    task automatic wr_alu(input logic [4:0] d, input logic [31:0] v);
        regWrite = 1'b1; regDest = 1'b1; memToReg = 1'b0; jalSignal = 1'b0;
        rd = d; aluData = v;
        #1;
        check("alu_nostall", {31'd0, stall}, 32'd0);
        push(d, v);
        tick();
        regWrite = 1'b0;
    endtask

    // Pop the oldest expectation and read it back through port A
    task automatic verify(input string tag);
        wb_stage_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            rs = e.dest;
            #1;
            check(tag, data1, e.data);
        end
    endtask

    initial begin
        resetN = 1'b0; rs = '0; rt = '0;
        idle_inputs();
        tick(); tick();
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_memerr", {31'd0, memError}, 32'd0);
        rs = 5'd1; #1;
        check("rst_rd1", data1, 32'd0);
        resetN = 1'b1;
        tick();

        // 1: load data, then asynchronous reset clears every index
        wr_alu(5'd7, 32'h0000_1234);
        wr_alu(5'd9, 32'h0000_5678);
        tick();
        verify("pre_rst_r7");
        verify("pre_rst_r9");
        resetN = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            rs = 5'(i); rt = 5'(31 - i);
            #1;
            check("rst_all_d1", data1, 32'd0);
            check("rst_all_d2", data2, 32'd0);
        end
        check("rst2_stall", {31'd0, stall}, 32'd0);
        check("rst2_memerr", {31'd0, memError}, 32'd0);
        tick();
        resetN = 1'b1;
        tick();

        // 2: ALU write to r5 and its visibility timing
        rs = 5'd5;
        regWrite = 1'b1; regDest = 1'b1; rd = 5'd5; aluData = 32'h00AA_AA00;
        #1;
        check("t2_nostall", {31'd0, stall}, 32'd0);
        push(5'd5, 32'h00AA_AA00);
        tick();
        regWrite = 1'b0;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("t2_cycle_n1", data1, 32'h00AA_AA00);
`else
        check("t2_cycle_n1", data1, 32'd0);
`endif
        tick();
        verify("t2_r5");

        // 3: write to r0 is swallowed in every cycle
        rs = 5'd0;
        regWrite = 1'b1; regDest = 1'b1; rd = 5'd0; aluData = 32'hFFFF_FFFF;
        #1;
        check("t3_pre", data1, 32'd0);
        push(5'd0, 32'hFFFF_FFFF);
        tick();
        regWrite = 1'b0;
        #1;
        check("t3_n1", data1, 32'd0);
        tick();
        verify("t3_r0");

        // 4: jal writes pc+4 to r31, ignoring rd
        wr_alu(5'd3, 32'h0000_0033);
        tick();
        verify("t4_r3_init");
        regWrite = 1'b1; jalSignal = 1'b1; regDest = 1'b1; rd = 5'd3;
        pc = 32'd15; aluData = 32'hDEAD_BEEF;
        #1;
        check("t4_nostall", {31'd0, stall}, 32'd0);
        push(5'd31, 32'd19);
        tick();
        idle_inputs();
        tick();
        verify("t4_r31");
        rt = 5'd3; #1;
        check("t4_r3_kept", data2, 32'h0000_0033);

        // 5: load waits three cycles for memValid
        regWrite = 1'b1; memToReg = 1'b1; regDest = 1'b0; rt = 5'd2;
        memValid = 1'b0; memData = 32'h0F0F_0F0F;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_stall", {31'd0, stall}, 32'd1);
            tick();
        end
        memValid = 1'b1;
        #1;
        check("t5_release", {31'd0, stall}, 32'd0);
        push(5'd2, 32'h0F0F_0F0F);
        tick();
        idle_inputs();
        tick();
        verify("t5_r2");

        // 6: load never valid -> timeout, sticky error, no write
        wr_alu(5'd4, 32'h0000_0044);
        tick();
        verify("t6_r4_init");
        regWrite = 1'b1; memToReg = 1'b1; regDest = 1'b0; rt = 5'd4;
        memValid = 1'b0; memData = 32'h0000_0BAD;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("t6_stall_cycles", 32'(n), 32'd15);
        check("t6_err_before", {31'd0, memError}, 32'd0);
        tick();
        check("t6_abort_nostall", {31'd0, stall}, 32'd0);
        check("t6_memerr", {31'd0, memError}, 32'd1);
        idle_inputs();
        tick();
        tick();
        rt = 5'd4; #1;
        check("t6_r4_kept", data2, 32'h0000_0044);
        rt = 5'd2; #1;
        check("t6_r2_kept", data2, 32'h0F0F_0F0F);
        wr_alu(5'd6, 32'h0000_0066);
        tick();
        verify("t6_next_req");
        check("t6_memerr_sticky", {31'd0, memError}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
